// File: rtl/vending_machine_param.sv
// Multi-item vending FSM: coin credit, per-item stock counters, serial largest-first change.
// Outputs decode registered state; coin_rej, sel_err and n_state are combinational.
module vending_machine_param #(
  parameter int NUM_ITEMS  = 4,
  parameter int SEL_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
  parameter int PRICE      = 15,
  parameter int COIN1_VAL  = 5,
  parameter int COIN2_VAL  = 10,
  parameter int COIN3_VAL  = 25,
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           in,
  input  logic                 sel_valid,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 out,
  output logic [SEL_W-1:0]     out_item,
  output logic [1:0]           change,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 coin_rej,
  output logic                 sel_err,
  output logic                 busy,
  output logic [1:0]           c_state,
  output logic [1:0]           n_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_e;

  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] C1_C      = CREDIT_W'(COIN1_VAL);
  localparam logic [CREDIT_W-1:0] C2_C      = CREDIT_W'(COIN2_VAL);
  localparam logic [CREDIT_W-1:0] C3_C      = CREDIT_W'(COIN3_VAL);
  localparam logic [STOCK_W-1:0]  STOCK_MAX = '1;
  localparam logic [STOCK_W-1:0]  STOCK_INI = STOCK_W'(INIT_STOCK);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    item_q, item_d;
  logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic [1:0]          chg_code;
  logic [CREDIT_W-1:0] chg_val;
  logic                accepting, sel_in_range, coin_ok, vend_ok;

  always_comb begin
    unique case (in)
      2'b01:   coin_val = C1_C;
      2'b10:   coin_val = C2_C;
      2'b11:   coin_val = C3_C;
      default: coin_val = '0;
    endcase
  end

  // Largest coin that still fits in the remaining credit.
  always_comb begin
    if (credit_q >= C3_C) begin
      chg_code = 2'b11; chg_val = C3_C;
    end else if (credit_q >= C2_C) begin
      chg_code = 2'b10; chg_val = C2_C;
    end else if (credit_q >= C1_C) begin
      chg_code = 2'b01; chg_val = C1_C;
    end else begin
      chg_code = 2'b00; chg_val = '0;
    end
  end

  assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_val};
  assign accepting    = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  assign sel_in_range = int'(sel) < NUM_ITEMS;
  assign coin_ok      = accepting && (in != 2'b00) && !cancel && !sel_valid && !coin_sum[CREDIT_W];
  assign vend_ok      = (state_q == ST_COLLECT) && sel_in_range &&
                        (credit_q >= PRICE_C) && (stock_q[sel] != '0);
  assign coin_rej     = (in != 2'b00) && !coin_ok;

  // NOTE: every variable written here gets a default first, so no latches are inferred.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    item_d   = item_q;
    stock_d  = stock_q;
    sel_err  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (cancel) begin
          if (state_q == ST_COLLECT) state_d = ST_CHANGE;
        end else if (sel_valid) begin
          if (vend_ok) begin
            state_d = ST_VEND;
            item_d  = sel;
          end else begin
            sel_err = 1'b1;
          end
        end else if (coin_ok) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          state_d  = ST_COLLECT;
        end else if (restock && (state_q == ST_IDLE) && (in == 2'b00) && sel_in_range) begin
          if (stock_q[sel] != STOCK_MAX) stock_d[sel] = stock_q[sel] + STOCK_W'(1);
        end
      end
      ST_VEND: begin
        credit_d        = credit_q - PRICE_C;
        stock_d[item_q] = stock_q[item_q] - STOCK_W'(1);
        state_d         = (credit_d == '0) ? ST_IDLE : ST_CHANGE;
      end
      ST_CHANGE: begin
        credit_d = credit_q - chg_val;
        if ((credit_d == '0) || (chg_val == '0)) begin
          credit_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      item_q   <= '0;
      // NOTE: stock is a small flop array, not a RAM, so it can be reset to its initial fill.
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_INI;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      item_q   <= item_d;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) sold_out[i] = (stock_q[i] == '0);
  end

  assign out      = (state_q == ST_VEND);
  assign out_item = out ? item_q : '0;
  assign change   = (state_q == ST_CHANGE) ? chg_code : 2'b00;
  assign credit   = credit_q;
  assign busy     = (state_q == ST_VEND) || (state_q == ST_CHANGE);
  assign c_state  = state_q;
  assign n_state  = state_d;

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: a behavioural model pushes expected
// post-edge outputs per driven cycle; they are popped and compared after the edge.
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       rst, sel_valid, cancel, restock;
  logic [1:0] in, sel;
  logic       out, coin_rej, sel_err, busy;
  logic [1:0] out_item, change, c_state, n_state;
  logic [7:0] credit;
  logic [3:0] sold_out;

  always #5 clk = ~clk;

  vending_machine_param dut (
    .clk(clk), .rst(rst), .in(in), .sel_valid(sel_valid), .sel(sel),
    .cancel(cancel), .restock(restock), .out(out), .out_item(out_item),
    .change(change), .credit(credit), .sold_out(sold_out), .coin_rej(coin_rej),
    .sel_err(sel_err), .busy(busy), .c_state(c_state), .n_state(n_state)
  );

  typedef struct packed {
    logic       out;
    logic [1:0] item;
    logic [1:0] change;
    logic [7:0] credit;
    logic       busy;
    logic [1:0] state;
    logic [3:0] sold;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   misses  = 0;

  int m_state = 0, m_credit = 0, m_item = 0;
  int m_stock[4] = '{3, 3, 3, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int coin_value(input logic [1:0] c);
    case (c)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 25;
      default: return 0;
    endcase
  endfunction

  function automatic int refund_value(input int c);
    if (c >= 25) return 25;
    if (c >= 10) return 10;
    if (c >= 5)  return 5;
    return 0;
  endfunction

  function automatic logic [1:0] refund_code(input int c);
    if (c >= 25) return 2'b11;
    if (c >= 10) return 2'b10;
    if (c >= 5)  return 2'b01;
    return 2'b00;
  endfunction

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic cyc(input logic r, input logic [1:0] coin, input logic sv,
                     input logic [1:0] s, input logic cn, input logic rs);
    exp_t e;
    int   ns, nc, ni, cv;
    int   nstk[4];
    logic acc, eerr;
    @(negedge clk);
    rst = r; in = coin; sel_valid = sv; sel = s; cancel = cn; restock = rs;
    cv = coin_value(coin);
    ns = m_state; nc = m_credit; ni = m_item; nstk = m_stock;
    acc = 1'b0; eerr = 1'b0;
    case (m_state)
      0, 1: begin
        if (cn) begin
          if (m_state == 1) ns = 3;
        end else if (sv) begin
          if (m_state == 1 && m_credit >= 15 && m_stock[s] > 0) begin
            ns = 2; ni = int'(s);
          end else eerr = 1'b1;
        end else if (coin != 2'b00) begin
          if (m_credit + cv <= 255) begin
            acc = 1'b1; nc = m_credit + cv; ns = 1;
          end
        end else if (rs && m_state == 0) begin
          if (nstk[s] < 15) nstk[s] = nstk[s] + 1;
        end
      end
      2: begin
        nc = m_credit - 15;
        nstk[m_item] = nstk[m_item] - 1;
        ns = (nc == 0) ? 0 : 3;
      end
      default: begin
        nc = m_credit - refund_value(m_credit);
        if (nc == 0) ns = 0;
      end
    endcase
    #1;
    if (!r) begin
      check("coin_rej", coin_rej, (coin != 2'b00) && !acc);
      check("sel_err", sel_err, eerr);
      check("n_state", n_state, ns);
    end
    if (r) begin
      ns = 0; nc = 0; ni = 0; nstk = '{3, 3, 3, 3};
    end
    m_state = ns; m_credit = nc; m_item = ni; m_stock = nstk;
    e.out    = (m_state == 2);
    e.item   = (m_state == 2) ? 2'(m_item) : 2'd0;
    e.change = (m_state == 3) ? refund_code(m_credit) : 2'b00;
    e.credit = 8'(m_credit);
    e.busy   = (m_state >= 2);
    e.state  = 2'(m_state);
    for (int i = 0; i < 4; i++) e.sold[i] = (m_stock[i] == 0);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("out", out, e.out);
    check("out_item", out_item, e.item);
    check("change", change, e.change);
    check("credit", credit, e.credit);
    check("busy", busy, e.busy);
    check("c_state", c_state, e.state);
    check("sold_out", sold_out, e.sold);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in = 2'b00; sel_valid = 1'b0; sel = '0; cancel = 1'b0; restock = 1'b0;
    cyc(1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
    check("reset_sold_out", sold_out, 4'b0000);

    // Exact price: 10 + 5, vend item 2.
    cyc(1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b1, 2'd2, 1'b0, 1'b0);
    check("s1_vend_item", out_item, 2'd2);
    idle(2);

    // Overpay with 25, vend item 1, one change coin of 10.
    cyc(1'b0, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0);
    idle(1);
    check("s2_change_code", change, 2'b10);
    idle(2);

    // Cancel with 50 credit: two 25 coins back, no vend.
    cyc(1'b0, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(3);

    // Drain item 0.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
      cyc(1'b0, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
      idle(1);
    end
    check("s4_sold_out0", sold_out[0], 1'b1);
    cyc(1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
    check("s4_credit_kept", credit, 8'd15);
    cyc(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(3);
    cyc(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1);
    check("s4_restocked", sold_out[0], 1'b0);
    idle(1);

    // Same-cycle conflicts.
    cyc(1'b0, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b1, 2'd3, 1'b0, 1'b0);
    cyc(1'b0, 2'b01, 1'b0, 2'd0, 1'b1, 1'b0);
    check("s5_refund_code", change, 2'b01);
    cyc(1'b0, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(2);

    // Credit saturation, then reset mid-refund.
    for (int k = 0; k < 10; k++) cyc(1'b0, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
    check("s6_credit_full", credit, 8'd250);
    cyc(1'b0, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
    check("s6_credit_sat", credit, 8'd250);
    cyc(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    check("s6_first_change", change, 2'b11);
    cyc(1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
    check("s6_rst_credit", credit, 8'd0);
    check("s6_rst_change", change, 2'b00);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
Parametrised successor to the single-product vending FSM. It accepts three coin denominations into a credit register and serves NUM_ITEMS products, each with its own stock counter. Change is returned serially, one coin per cycle, largest coin first. Cancel and refund, restock, and sold-out flags are included; c_state and n_state are exported for debug.

Parameters:
NUM_ITEMS, 4, number of products; SEL_W = max(1, clog2(NUM_ITEMS))
PRICE, 15, price of every item, in credit units
COIN1_VAL, 5, value of coin code 2'b01
COIN2_VAL, 10, value of coin code 2'b10
COIN3_VAL, 25, value of coin code 2'b11
CREDIT_W, 8, credit register width
STOCK_W, 4, stock counter width per item
INIT_STOCK, 3, stock value loaded at reset
Constraints: PRICE, COIN2_VAL and COIN3_VAL are multiples of COIN1_VAL; COIN1_VAL < COIN2_VAL < COIN3_VAL; PRICE <= 2^CREDIT_W-1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in  in  2  coin inserted this cycle (00 none, 01/10/11 = COIN1/2/3)
sel_valid  in  1  purchase request, single cycle
sel  in  SEL_W  item index for purchase or restock
cancel  in  1  refund request
restock  in  1  add one unit to stock[sel]
out  out  1  vend pulse
out_item  out  SEL_W  item being vended; 0 when out=0
change  out  2  coin code returned this cycle, 00 none
credit  out  CREDIT_W  current credit
sold_out  out  NUM_ITEMS  bit i = 1 when stock[i]==0
coin_rej  out  1  the coin on in this cycle was not accepted
sel_err  out  1  the selection presented this cycle was refused
busy  out  1  state is VEND or CHANGE
c_state  out  2  registered state
n_state  out  2  combinational next state

Behaviour:
- States: IDLE=0, COLLECT=1, VEND=2, CHANGE=3. All updates occur on the rising edge of clk.
- Reset (rst=1 at an edge, any state, overrides all inputs):
  - state IDLE, credit 0, every stock = INIT_STOCK, latched item 0.
  - Following cycle: out=0, change=00, busy=0.
  - A reset during CHANGE forfeits the remaining credit.
- Output timing: out, out_item, change, busy and credit decode registered state only (Moore). coin_rej, sel_err and n_state are combinational from the current inputs and state.
- Coin acceptance:
  - A coin is accepted only in IDLE or COLLECT, and only when cancel=0 and sel_valid=0.
  - Accepted coin: credit += value at the next edge.
  - The coin is rejected (coin_rej=1, credit unchanged) when:
    - credit + value > 2^CREDIT_W-1, or
    - cancel or sel_valid is high in the same cycle, or
    - the state is VEND or CHANGE.
- Priority within IDLE/COLLECT: cancel > sel_valid > coin > restock.
- IDLE:
  - Accepted coin -> COLLECT.
  - restock=1 (no coin, no cancel, no sel_valid): stock[sel] += 1, saturating at 2^STOCK_W-1.
  - sel_valid -> sel_err=1.
  - cancel with credit 0 -> no-op.
- COLLECT:
  - cancel -> CHANGE.
  - sel_valid with credit >= PRICE and stock[sel] > 0 -> VEND; latch sel.
  - sel_valid otherwise -> sel_err=1, stay in COLLECT, credit unchanged.
  - sel is evaluated against the registered credit.
  - restock is ignored.
- VEND (exactly one cycle):
  - out=1, out_item = latched sel.
  - At the edge leaving VEND: stock[item] -= 1 and credit -= PRICE.
  - Next state: IDLE if the new credit is 0, else CHANGE.
- CHANGE:
  - change = code of the largest coin value <= credit.
  - At each edge, credit -= that value.
  - Go to IDLE at the edge where credit reaches 0; otherwise stay.
  - The parameter constraints guarantee termination.
  - sel_valid, cancel and restock are ignored; coins are rejected.
- sold_out updates at the same edge as the stock change.

Test Plan:
- Reset; coin 10 then 5; sel=2 -> out=1 with out_item=2 one cycle after sel; then IDLE, credit 0, stock[2]=2, change stays 00.
- Coin 25; sel=1 -> VEND for 1 cycle; CHANGE for 1 cycle with change=10 (code 2'b10); credit 0; IDLE.
- Coins 25, 25 (credit 50); cancel -> change=11 for two consecutive cycles; credit 50->25->0; IDLE; out never asserted.
- Vend item 0 three times (credit 15 each) -> sold_out[0]=1.
  - Next: credit 15, sel=0 -> sel_err=1, credit stays 15.
  - restock in COLLECT is ignored.
  - cancel returns 10 then 5.
  - restock sel=0 in IDLE -> stock[0]=1, sold_out[0]=0.
- Same-cycle conflicts:
  - Credit 5, sel=3 -> sel_err=1.
  - Coin with cancel in the same cycle -> coin_rej=1, refund of 5.
  - Coin during CHANGE -> coin_rej=1, credit unaffected.
- Saturation and reset:
  - Ten 25-coins -> credit 250; an eleventh 25 -> coin_rej=1, credit 250.
  - Cancel, then rst after the first change coin -> next cycle change=00, credit 0, IDLE, all stock 3.
